// File: rtl/mcu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcu_bus_pkg
// Description : Shared widths, FSM encodings and mux codes for mcu_bus_fabric.
// Revision    : 1.0  initial release
// ============================================================================
package mcu_bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int MSEL_W = 4;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_WAIT = 1'b1;

    // Mux index meaning "no slot": NSLOT never exceeds 8, so 15 is free.
    localparam logic [MSEL_W-1:0] MSEL_NONE = 4'hF;
endpackage
`default_nettype wire

// File: rtl/mcu_bus_fabric_decode.sv
`default_nettype none
// ============================================================================
// Module      : bus_slot_decode
// Description : Priority address match; lowest-index slot wins on overlap.
// Revision    : 1.0  initial release
// ============================================================================
module bus_slot_decode
    import mcu_bus_pkg::*;
#(
    parameter int                     NSLOT     = 4,
    parameter logic [NSLOT*16-1:0]    SLOT_BASE = {16'hF000, 16'hE000, 16'hD000, 16'h0000},
    parameter logic [NSLOT*16-1:0]    SLOT_MASK = {16'hF000, 16'hF000, 16'hF000, 16'h8000},
    parameter logic [NSLOT*4-1:0]     SLOT_WAIT = {4'd0, 4'd2, 4'd0, 4'd0}
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NSLOT-1:0]  sel,
    output logic [MSEL_W-1:0] idx,
    output logic              hit,
    output logic [CNT_W-1:0]  wait_cnt
);
    logic [NSLOT-1:0] w_match;

    generate
        for (genvar g = 0; g < NSLOT; g++) begin : g_match
            assign w_match[g] = (addr & SLOT_MASK[16*g +: 16]) ==
                                (SLOT_BASE[16*g +: 16] & SLOT_MASK[16*g +: 16]);
        end
    endgenerate

    // Scan from the top down so the lowest matching index overrides.
    always_comb begin
        sel      = '0;
        idx      = MSEL_NONE;
        hit      = 1'b0;
        wait_cnt = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                sel      = '0;
                sel[i]   = 1'b1;
                idx      = MSEL_W'(i);
                hit      = 1'b1;
                wait_cnt = SLOT_WAIT[4*i +: 4];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mcu_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module      : mcu_bus_fabric
// Description : 6502 bus fabric: slot decode, wait-state RDY FSM, read mux.
//               Optional error log enabled by MCU_BUS_ERRLOG_EN.
// Revision    : 1.0  initial release
// ============================================================================
module mcu_bus_fabric
    import mcu_bus_pkg::*;
#(
    parameter int                     NSLOT      = 4,
    parameter logic [NSLOT*16-1:0]    SLOT_BASE  = {16'hF000, 16'hE000, 16'hD000, 16'h0000},
    parameter logic [NSLOT*16-1:0]    SLOT_MASK  = {16'hF000, 16'hF000, 16'hF000, 16'h8000},
    parameter logic [NSLOT*4-1:0]     SLOT_WAIT  = {4'd0, 4'd2, 4'd0, 4'd0},
    parameter logic [7:0]             DEFAULT_DI = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          cpu_ab,
    input  logic                 cpu_we,
    output logic                 cpu_rdy,
    output logic [7:0]           cpu_di,
    output logic [NSLOT-1:0]     slot_sel,
    output logic [NSLOT-1:0]     slot_we,
    input  logic [NSLOT*8-1:0]   slot_dout,
    output logic                 bus_err
`ifdef MCU_BUS_ERRLOG_EN
    ,
    output logic [15:0]          err_addr,
    output logic                 err_valid,
    input  logic                 err_clr
`endif
);
    logic              w_hit;
    logic [MSEL_W-1:0] w_idx;
    logic [CNT_W-1:0]  w_wait;
    state_t            r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [MSEL_W-1:0] r_msel;
    logic              w_done;
    logic              w_complete;

    bus_slot_decode #(
        .NSLOT     (NSLOT),
        .SLOT_BASE (SLOT_BASE),
        .SLOT_MASK (SLOT_MASK),
        .SLOT_WAIT (SLOT_WAIT)
    ) u_decode (
        .addr     (cpu_ab),
        .sel      (slot_sel),
        .idx      (w_idx),
        .hit      (w_hit),
        .wait_cnt (w_wait)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_hit && (w_wait != '0)) begin
                    w_state_nx = ST_WAIT;
                    w_cnt_nx   = w_wait - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) w_cnt_nx   = r_cnt - CNT_W'(1);
                else             w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Reset forces RDY high but suppresses any strobe of an abandoned access.
    always_comb begin
        w_done = 1'b1;
        case (r_state)
            ST_IDLE: w_done = !(w_hit && (w_wait != '0));
            ST_WAIT: w_done = (r_cnt == '0);
            default: w_done = 1'b1;
        endcase
        w_complete = w_done && !reset;
        cpu_rdy    = w_done || reset;
        slot_we    = (w_complete && cpu_we) ? slot_sel : '0;
        bus_err    = w_complete && !w_hit;
    end

    always_ff @(posedge clk) begin
        if (reset)           r_msel <= MSEL_NONE;
        else if (w_complete) r_msel <= w_idx;
    end

    always_comb begin
        cpu_di = DEFAULT_DI;
        for (int i = 0; i < NSLOT; i++) begin
            if (r_msel == MSEL_W'(i)) cpu_di = slot_dout[8*i +: 8];
        end
    end

`ifdef MCU_BUS_ERRLOG_EN
    // A new error beats a simultaneous clear and captures its address.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr  <= '0;
            err_valid <= 1'b0;
        end else if (bus_err && (!err_valid || err_clr)) begin
            err_addr  <= cpu_ab;
            err_valid <= 1'b1;
        end else if (err_clr) begin
            err_valid <= 1'b0;
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_mcu_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcu_bus_fabric
// Description : Self-checking bench for mcu_bus_fabric (vectors + random model).
// Revision    : 1.0  initial release
// ============================================================================
module tb_mcu_bus_fabric;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic        cpu_we;
    logic        cpu_rdy;
    logic [7:0]  cpu_di;
    logic [3:0]  slot_sel;
    logic [3:0]  slot_we;
    logic [31:0] slot_dout;
    logic        bus_err;
    logic        err_clr;
    logic [15:0] err_addr;
    logic        err_valid;

    logic [15:0] ab2;
    logic        rdy2, err2;
    logic [7:0]  di2;
    logic [3:0]  sel2, we2;
    logic [15:0] err_addr2;
    logic        err_valid2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mcu_bus_fabric dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ab    (cpu_ab),
        .cpu_we    (cpu_we),
        .cpu_rdy   (cpu_rdy),
        .cpu_di    (cpu_di),
        .slot_sel  (slot_sel),
        .slot_we   (slot_we),
        .slot_dout (slot_dout),
        .bus_err   (bus_err)
`ifdef MCU_BUS_ERRLOG_EN
        ,
        .err_addr  (err_addr),
        .err_valid (err_valid),
        .err_clr   (err_clr)
`endif
    );

    // Second instance with slot 1 overlapping slot 0.
    mcu_bus_fabric #(
        .SLOT_BASE ({16'hF000, 16'hE000, 16'h0000, 16'h0000}),
        .SLOT_MASK ({16'hF000, 16'hF000, 16'hC000, 16'h8000})
    ) dut_ovl (
        .clk       (clk),
        .reset     (reset),
        .cpu_ab    (ab2),
        .cpu_we    (1'b0),
        .cpu_rdy   (rdy2),
        .cpu_di    (di2),
        .slot_sel  (sel2),
        .slot_we   (we2),
        .slot_dout (32'h0),
        .bus_err   (err2)
`ifdef MCU_BUS_ERRLOG_EN
        ,
        .err_addr  (err_addr2),
        .err_valid (err_valid2),
        .err_clr   (1'b0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference memory map: RAM 0000-7FFF, D/E/F pages; E page has 2 waits.
    function automatic int ref_slot(input logic [15:0] a);
        if (a < 16'h8000)        return 0;
        if (a[15:12] == 4'hD)    return 1;
        if (a[15:12] == 4'hE)    return 2;
        if (a[15:12] == 4'hF)    return 3;
        return -1;
    endfunction

    function automatic int ref_waits(input int s);
        return (s == 2) ? 2 : 0;
    endfunction

    // Entered just after a rising edge; leaves just after the edge following completion.
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                          input int es, input int ew, input logic [7:0] edi);
        logic [3:0] esel;
        esel = (es < 0) ? 4'b0000 : 4'(1 << es);
        cpu_ab    = a;
        cpu_we    = w;
        slot_dout = {$urandom};
        if (es >= 0) slot_dout[es*8 +: 8] = d;
        for (int k = 0; k <= ew; k++) begin
            @(negedge clk);
            chk("slot_sel", 32'(slot_sel), 32'(esel));
            chk("cpu_rdy",  32'(cpu_rdy),  32'(k == ew));
            chk("slot_we",  32'(slot_we),  (k == ew && w) ? 32'(esel) : 32'h0);
            chk("bus_err",  32'(bus_err),  32'(k == ew && es < 0));
            @(posedge clk); #1;
        end
        chk("cpu_di", 32'(cpu_di), 32'(edi));
    endtask

    typedef struct {
        logic [15:0] ab;
        logic        we;
        logic [7:0]  dout;
        int          slot;
        int          waits;
        logic [7:0]  di;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h0123, 1'b0, 8'h5A, 0,  0, 8'h5A};
        vecs[1] = '{16'hE001, 1'b0, 8'hA7, 2,  2, 8'hA7};
        vecs[2] = '{16'hE000, 1'b1, 8'h3C, 2,  2, 8'h3C};
        vecs[3] = '{16'h8000, 1'b0, 8'h00, -1, 0, 8'hFF};
        vecs[4] = '{16'hD042, 1'b1, 8'h11, 1,  0, 8'h11};
        vecs[5] = '{16'hFFFC, 1'b0, 8'hC3, 3,  0, 8'hC3};

        reset = 1'b1; cpu_ab = 16'hE000; cpu_we = 1'b1; slot_dout = 32'h12345678;
        err_clr = 1'b0; ab2 = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rdy",     32'(cpu_rdy), 32'h1);
        chk("reset di",      32'(cpu_di),  32'hFF);
        chk("reset slot_we", 32'(slot_we), 32'h0);
        chk("reset bus_err", 32'(bus_err), 32'h0);
`ifdef MCU_BUS_ERRLOG_EN
        chk("reset err_valid", 32'(err_valid), 32'h0);
        chk("reset err_addr",  32'(err_addr),  32'h0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i])
            access(vecs[i].ab, vecs[i].we, vecs[i].dout, vecs[i].slot, vecs[i].waits, vecs[i].di);

`ifdef MCU_BUS_ERRLOG_EN
        chk("errlog addr", 32'(err_addr), 32'h8000);
        access(16'h9000, 1'b0, 8'h00, -1, 0, 8'hFF);
        chk("errlog keep", 32'(err_addr), 32'h8000);
        chk("errlog valid", 32'(err_valid), 32'h1);
        err_clr = 1'b1;
        access(16'h0010, 1'b0, 8'h21, 0, 0, 8'h21);
        err_clr = 1'b0;
        chk("errlog clr", 32'(err_valid), 32'h0);
        err_clr = 1'b1;
        access(16'hA000, 1'b0, 8'h00, -1, 0, 8'hFF);
        err_clr = 1'b0;
        chk("errlog clr+err valid", 32'(err_valid), 32'h1);
        chk("errlog clr+err addr",  32'(err_addr),  32'hA000);
`endif

        // Reset in the second cycle of a waited write abandons it.
        cpu_ab = 16'hE000; cpu_we = 1'b1;
        @(negedge clk);
        chk("midwait A rdy", 32'(cpu_rdy), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midwait rst slot_we", 32'(slot_we), 32'h0);
        chk("midwait rst rdy",     32'(cpu_rdy), 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midwait rst di", 32'(cpu_di), 32'hFF);
        access(16'hE000, 1'b1, 8'h77, 2, 2, 8'h77);

        // Overlap priority on the second instance.
        ab2 = 16'h0010;
        @(negedge clk);
        chk("overlap 0010", 32'(sel2), 32'h1);
        ab2 = 16'h3FFF;
        @(negedge clk);
        chk("overlap 3FFF", 32'(sel2), 32'h1);
        ab2 = 16'h8010;
        @(negedge clk);
        chk("overlap 8010 unmapped", 32'(sel2), 32'h0);
        @(posedge clk); #1;

        for (int n = 0; n < 200; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            int          s;
            a = 16'($urandom);
            d = 8'($urandom);
            s = ref_slot(a);
            access(a, 1'($urandom), d, s, (s < 0) ? 0 : ref_waits(s), (s < 0) ? 8'hFF : d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mcu_bus_fabric.md
# mcu_bus_fabric

Parametrised 6502 system-bus fabric for the iceMCU family. It replaces hard-wired four-way page decoding and the fixed read-data mux with N configurable address slots. Each slot has a programmable number of wait states that drive CPU RDY, and unmapped accesses are detected. It sits between the `cpu` core and the RAM, GPIO, ACIA and ROM slaves.

## Interface
- `NSLOT`, 4: number of slave slots, 1..8.
- `SLOT_BASE`, {16'hF000,16'hE000,16'hD000,16'h0000}: packed NSLOT×16 slot base addresses; slot i is at bits [16i+15:16i].
- `SLOT_MASK`, {16'hF000,16'hF000,16'hF000,16'h8000}: packed NSLOT×16 compare masks.
- `SLOT_WAIT`, {4'd0,4'd2,4'd0,4'd0}: packed NSLOT×4 wait states per slot, 0..15.
- `DEFAULT_DI`, 8'hFF: read data returned for an unmapped access and after reset.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `cpu_ab` in 16: CPU address bus.
- `cpu_we` in 1: CPU write enable.
- `cpu_rdy` out 1: CPU RDY. Low stalls the CPU.
- `cpu_di` out 8: read data to the CPU.
- `slot_sel` out NSLOT: one-hot slot select, combinational from `cpu_ab`.
- `slot_we` out NSLOT: one-hot write strobe, asserted only in the completing cycle.
- `slot_dout` in NSLOT×8: packed slave read data; slaves have 1-cycle synchronous read latency.
- `bus_err` out 1: one-cycle pulse on completion of an unmapped access.
- `err_addr` out 16: present only with `MCU_BUS_ERRLOG_EN`.
- `err_valid` out 1: present only with `MCU_BUS_ERRLOG_EN`.
- `err_clr` in 1: present only with `MCU_BUS_ERRLOG_EN`.

## Operation
- **Hit rule:** slot i hits when `(cpu_ab & MASK_i) == (BASE_i & MASK_i)`.
- **Overlapping hits:** the lowest index wins, so `slot_sel` is always one-hot or zero.
- **No hit:** the access is unmapped. It takes 0 wait states and reads `DEFAULT_DI`.
- **FSM states:** IDLE and WAIT, plus a 4-bit counter `cnt`.
  - IDLE, hit slot has w = 0: `cpu_rdy` = 1; stay in IDLE.
  - IDLE, hit slot has w > 0: `cpu_rdy` = 0; load `cnt` ← w−1; go to WAIT.
  - WAIT, `cnt` ≠ 0: `cpu_rdy` = 0; `cnt` decrements.
  - WAIT, `cnt` = 0: `cpu_rdy` = 1; go to IDLE.
- **Completing cycle:** the cycle in which `cpu_rdy` = 1.
  - `slot_we[i]` = `cpu_we & slot_sel[i]` in the completing cycle only, so a slave sees exactly one write per access.
  - The registered mux index `msel` captures the hit slot, or an "unmapped" code.
- **Read data:** `cpu_di` = `slot_dout[msel]`, or `DEFAULT_DI` when `msel` is unmapped.
  - `msel` holds while `cpu_rdy` = 0, so `cpu_di` is stable through a stall.
- **Address held during a stall:** the CPU holds `cpu_ab`.
  - `slot_sel` remains asserted for the whole access, including every wait cycle.
- **Reset values:** state IDLE, `cnt` = 0, `msel` = unmapped (`cpu_di` = `DEFAULT_DI`), `bus_err` = 0, `err_valid` = 0, `err_addr` = 0.
  - `cpu_rdy` = 1 while `reset` is high.
- **Reset mid-WAIT:** the access is abandoned. No `slot_we` is issued and the next cycle is IDLE.

## Timing
- Address valid in cycle A with wait w: `cpu_rdy` is low in cycles A..A+w−1 and high in A+w.
- Read data is valid on `cpu_di` in cycle A+w+1.
- Back-to-back accesses: a new address in cycle A+w+1 is decoded in IDLE with no bubble.
- `bus_err` pulses in the completing cycle of an unmapped access, which is cycle A.
- Combinational paths: `cpu_ab` → `slot_sel`, `cpu_rdy`, `slot_we`. `cpu_di` depends only on `msel` and `slot_dout`.

## Configuration
- `MCU_BUS_ERRLOG_EN` defined:
  - On the first unmapped access while `err_valid` = 0, latch `err_addr` ← `cpu_ab` and set `err_valid`.
  - Later errors do not overwrite the latched address.
  - `err_clr` clears `err_valid` next cycle; if an error coincides with `err_clr`, the error wins and is latched.
- Undefined: the error-log ports and registers are absent; only `bus_err` is produced.

## Structure
- Shared package `mcu_bus_pkg` holds:
  - the address width (16) and data width (8);
  - the wait-counter width (4);
  - the FSM state encodings;
  - the `MSEL_NONE` code.
- One sub-module, `bus_slot_decode`: combinational priority match of `cpu_ab` against the slots, outputting the one-hot select, the hit index, the hit flag and the wait value.
- The FSM, `msel` register and error log live in the top module.

## Test plan
- **RAM read, 0 waits:** `cpu_ab` = 16'h0123, slot 0 drives 8'h5A → `slot_sel` = 4'b0001, `cpu_rdy` = 1 throughout, `cpu_di` = 8'h5A in cycle A+1.
- **ACIA read, 2 waits:** `cpu_ab` = 16'hE001 → `cpu_rdy` low in A and A+1, high in A+2; `cpu_di` = slot 2 data in A+3; `slot_sel[2]` high from A through A+2.
- **Waited write:** write 8'h3C to 16'hE000 → `slot_we[2]` high only in A+2; exactly one strobe.
- **Unmapped access:** read 16'h8000 → `cpu_rdy` = 1, `bus_err` pulses in A, `cpu_di` = 8'hFF in A+1. With `MCU_BUS_ERRLOG_EN`: `err_addr` = 16'h8000; a second error at 16'h9000 leaves `err_addr` unchanged; `err_clr` then clears `err_valid`.
- **Overlap priority:** set `SLOT_BASE[1]` = 16'h0000, `SLOT_MASK[1]` = 16'hC000; access 16'h0010 → `slot_sel` = 4'b0001.
- **Reset mid-WAIT:** assert `reset` in A+1 of a write to 16'hE000 → no `slot_we`, state IDLE, `cpu_rdy` = 1, `cpu_di` = 8'hFF.
